// File: rtl/iob_mem_responder_pkg.sv
// Shared types and constants for the IOB memory responder.
// FSM state encoding and LFSR constants used by the stall generator.
package iob_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/iob_mem_responder_if.sv
// IOB request/response bus between requester and memory responder.
// Signal names keep the responder-side _i/_o direction suffixes.
interface iob_mem_responder_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  localparam int NB = DATA_W / 8;
  localparam int AW = ADDR_W + $clog2(NB);

  logic              iob_valid_i;
  logic [AW-1:0]     iob_addr_i;
  logic [DATA_W-1:0] iob_wdata_i;
  logic [NB-1:0]     iob_wstrb_i;
  logic              iob_ready_o;
  logic              iob_rvalid_o;
  logic [DATA_W-1:0] iob_rdata_o;

  modport master (
    output iob_valid_i,
    output iob_addr_i,
    output iob_wdata_i,
    output iob_wstrb_i,
    input  iob_ready_o,
    input  iob_rvalid_o,
    input  iob_rdata_o
  );

  modport slave (
    input  iob_valid_i,
    input  iob_addr_i,
    input  iob_wdata_i,
    input  iob_wstrb_i,
    output iob_ready_o,
    output iob_rvalid_o,
    output iob_rdata_o
  );

endinterface

// File: rtl/iob_mem_responder_lfsr.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running.
// Reloads the seed while reset is held.
module iob_mem_responder_lfsr
  import iob_mem_responder_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/iob_mem_responder.sv
// IOB memory responder: byte-strobed writes, fixed-latency reads.
// Define IOB_MEM_RESPONDER_STALL_EN for pseudo-random ready stalls.
module iob_mem_responder
  import iob_mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input logic clk_i,
  input logic rst_n_i,
  iob_mem_responder_if.slave bus
);

  localparam int NB    = DATA_W / 8;
  localparam int OFS   = $clog2(NB);
  localparam int AW    = ADDR_W + OFS;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              stall;
  logic              ready;
  logic              accept;
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] idx;
  logic              unused_addr;

`ifdef IOB_MEM_RESPONDER_STALL_EN
  logic [7:0] lfsr_w;
  logic       unused_lfsr;

  iob_mem_responder_lfsr u_lfsr (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .lfsr_o (lfsr_w)
  );

  assign stall       = (lfsr_w[1:0] == 2'b00);
  assign unused_lfsr = ^lfsr_w[7:2];
`else
  assign stall = 1'b0;
`endif

  assign idx         = bus.iob_addr_i[AW-1:OFS];
  assign unused_addr = ^bus.iob_addr_i;

  // Reset forces ready low so no edge in reset can touch memory.
  assign ready  = rst_n_i && (state_q != WAIT) && !stall;
  assign accept = bus.iob_valid_i && ready;
  assign wr     = accept && (|bus.iob_wstrb_i);
  assign rd     = accept && !(|bus.iob_wstrb_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (rd) begin
          cap_d = mem_q[idx];
          if (LATENCY == 1) begin
            state_d = RESP;
            rdata_d = mem_q[idx];
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          rdata_d = cap_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      cap_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.iob_wstrb_i[b]) begin
          mem_q[idx][8*b +: 8] <= bus.iob_wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign bus.iob_ready_o  = ready;
  assign bus.iob_rvalid_o = (state_q == RESP);
  assign bus.iob_rdata_o  = rdata_q;

endmodule

// File: tb/tb_iob_mem_responder.sv
// Self-checking bench for iob_mem_responder: directed vectors plus
// a word-level memory model compared against the DUT every cycle.
module tb_iob_mem_responder;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int LATENCY = 2;
  localparam int AW      = ADDR_W + 2;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;

  always #5 clk_i = ~clk_i;

  iob_mem_responder_if #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) bus ();

  iob_mem_responder #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LATENCY(LATENCY)
  ) dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .bus    (bus)
  );

  int          passed     = 0;
  int          total      = 0;
  int          cyc        = 0;
  int          due        = 0;
  int          stall_idle = 0;
  bit          pend       = 1'b0;
  bit          armed      = 1'b0;
  bit          rdy_s      = 1'b0;
  logic [31:0] pdata      = '0;
  logic [31:0] hold       = '0;
  logic [31:0] mm [int];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d",
                  nm, act, exp, cyc);
  endtask

  // Model: one outstanding read, due LATENCY-1 edges after accept.
  initial begin : model
    int          w;
    logic [31:0] v;
    forever begin
      @(posedge clk_i);
      cyc++;
      armed = 1'b1;
      if (pend && cyc > due) pend = 1'b0;
      if (!rst_n_i) begin
        pend = 1'b0;
        hold = '0;
      end else if (bus.iob_valid_i && rdy_s) begin
        w = int'(bus.iob_addr_i[AW-1:2]);
        if (bus.iob_wstrb_i != 4'h0) begin
          v = mm.exists(w) ? mm[w] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (bus.iob_wstrb_i[b])
              v[8*b +: 8] = bus.iob_wdata_i[8*b +: 8];
          mm[w] = v;
        end else begin
          pend  = 1'b1;
          pdata = mm.exists(w) ? mm[w] : 'x;
          due   = cyc + LATENCY - 1;
        end
      end
      if (pend && cyc == due) hold = pdata;
    end
  end

  initial begin : compare
    bit exp_rv;
    bit in_wait;
    forever begin
      @(negedge clk_i);
      rdy_s = bus.iob_ready_o;
      if (armed) begin
        exp_rv  = pend && (cyc == due);
        in_wait = pend && (cyc < due);
        chk("rvalid", 32'(bus.iob_rvalid_o), 32'(exp_rv));
        chk("rdata", bus.iob_rdata_o, hold);
`ifdef IOB_MEM_RESPONDER_STALL_EN
        if (in_wait) chk("ready_wait", 32'(bus.iob_ready_o), 32'd0);
        if (rst_n_i && !pend && !bus.iob_ready_o) stall_idle++;
`else
        chk("ready", 32'(bus.iob_ready_o),
            32'(rst_n_i && !in_wait));
`endif
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic idle();
    bus.iob_valid_i = 1'b0;
    bus.iob_wstrb_i = 4'h0;
  endtask

  task automatic req(input int a, input logic [31:0] d,
                     input logic [3:0] s, output logic rv,
                     output logic [31:0] rd);
    int nk;
    bus.iob_valid_i = 1'b1;
    bus.iob_addr_i  = AW'(a);
    bus.iob_wdata_i = d;
    bus.iob_wstrb_i = s;
    nk = 0;
    rv = 1'b0;
    rd = '0;
    forever begin
      @(negedge clk_i);
      nk++;
      if (bus.iob_ready_o) begin
        rv = bus.iob_rvalid_o;
        rd = bus.iob_rdata_o;
        break;
      end
      if (nk > 100) begin
        chk("req_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic op(input int a, input logic [31:0] d,
                    input logic [3:0] s);
    logic        rv;
    logic [31:0] rd;
    req(a, d, s, rv, rd);
  endtask

  task automatic wait_rv(output logic [31:0] d, output int k,
                         output logic r1);
    k  = 0;
    d  = '0;
    r1 = 1'b1;
    forever begin
      @(negedge clk_i);
      k++;
      if (k == 1) r1 = bus.iob_ready_o;
      if (bus.iob_rvalid_o) begin
        d = bus.iob_rdata_o;
        break;
      end
      if (k > 40) begin
        chk("rvalid_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin : stim
    logic [31:0] d;
    logic        rv;
    logic [31:0] rd;
    logic        r1;
    int          k;
    int          wa;
    bus.iob_valid_i = 1'b0;
    bus.iob_addr_i  = '0;
    bus.iob_wdata_i = '0;
    bus.iob_wstrb_i = '0;
    rst_n_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", 32'(bus.iob_ready_o), 32'd1);
    chk("rst_rvalid", 32'(bus.iob_rvalid_o), 32'd0);
    chk("rst_rdata", bus.iob_rdata_o, 32'h0);
    @(posedge clk_i);
    #1;

    op(0, 32'hDEADBEEF, 4'hF);
    op(0, 32'h0, 4'h0);
    idle();
    wait_rv(d, k, r1);
    chk("lat2_cycles", 32'(k), 32'd2);
    chk("lat2_data", d, 32'hDEADBEEF);
    chk("lat2_wait_ready", 32'(r1), 32'd0);

    op(4, 32'h11223344, 4'hF);
    op(4, 32'hAABBCCDD, 4'h5);
    op(4, 32'h0, 4'h0);
    idle();
    wait_rv(d, k, r1);
    chk("strb_merge", d, 32'h11BB33DD);

    for (int i = 0; i < 5; i++) op(4 * i, 32'(12 * i), 4'hF);
    for (int i = 0; i < 5; i++) begin
      req(4 * i, 32'h0, 4'h0, rv, rd);
`ifndef IOB_MEM_RESPONDER_STALL_EN
      if (i > 0) begin
        chk("b2b_rvalid", 32'(rv), 32'd1);
        chk("b2b_rdata", rd, 32'(12 * (i - 1)));
      end
`endif
    end
    idle();
    wait_rv(d, k, r1);
    chk("b2b_last", d, 32'd48);

    op(8, 32'h0, 4'h0);
    idle();
    rst_n_i = 1'b0;
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      chk("rst_drop_rvalid", 32'(bus.iob_rvalid_o), 32'd0);
    end
    @(posedge clk_i);
    #1;
    op(8, 32'h0, 4'h0);
    idle();
    wait_rv(d, k, r1);
    chk("rst_drop_reread", d, 32'd24);

    for (int w = 0; w < 16; w++) op(4 * w, $urandom, 4'hF);
    for (int n = 0; n < 200; n++) begin
      wa = 4 * int'($urandom_range(0, 15));
      op(wa, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk_i);
        #1;
      end
    end
    idle();
    repeat (LATENCY + 3) @(posedge clk_i);
    @(negedge clk_i);
`ifdef IOB_MEM_RESPONDER_STALL_EN
    chk("stall_seen", 32'(stall_idle > 0), 32'd1);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/iob_mem_responder.md
IOB_MEM_RESPONDER -- requirements
Module: iob_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width; memory depth 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 32, data width in bits; multiple of 8; NB = DATA_W/8.
REQ-003 SHALL have parameter LATENCY, default 2, cycles from read accept to rvalid; legal range 1..15.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n_i  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port iob_valid_i  input  1  request valid.
REQ-007 SHALL have port iob_addr_i  input  ADDR_W+log2(NB)  byte address.
REQ-008 SHALL have port iob_wdata_i  input  DATA_W  write data.
REQ-009 SHALL have port iob_wstrb_i  input  NB  byte strobes; nonzero = write, zero = read.
REQ-010 SHALL have port iob_ready_o  output  1  responder can accept a request this cycle.
REQ-011 SHALL have port iob_rvalid_o  output  1  read data valid, one-cycle pulse.
REQ-012 SHALL have port iob_rdata_o  output  DATA_W  read data.

Function
REQ-013 A request SHALL be accepted on a rising edge where iob_valid_i and iob_ready_o are both 1; no other edge has any effect on memory.
REQ-014 Word index SHALL be iob_addr_i[ADDR_W+log2(NB)-1 : log2(NB)]; low byte-offset bits SHALL be ignored.
REQ-015 Accepted write SHALL update exactly the bytes whose strobe is 1 at that edge; no rvalid is generated; iob_ready_o SHALL remain 1 (back-to-back writes at one per cycle).
REQ-016 FSM states: IDLE (ready=1), WAIT (ready=0, latency counter running), RESP (rvalid=1).
REQ-017 Read accepted in IDLE at edge T: memory word captured at T; if LATENCY=1, go to RESP; otherwise go to WAIT with counter loaded to LATENCY-1.
REQ-018 WAIT SHALL decrement the counter each cycle and go to RESP when the counter reaches 1.
REQ-019 iob_rvalid_o SHALL be 1 for exactly the single cycle following edge T+LATENCY-1, with iob_rdata_o equal to the word captured at T.
REQ-020 In RESP, iob_ready_o SHALL be 1, so a new request can be accepted in the same cycle as rvalid; FSM then follows REQ-015/REQ-017 or returns to IDLE.
REQ-021 Exactly one read SHALL be outstanding; iob_ready_o SHALL be 0 throughout WAIT.
REQ-022 iob_rdata_o SHALL hold its last value when rvalid is 0.
REQ-023 Latency counter width SHALL be 4 bits and SHALL never underflow.

Reset
REQ-024 While rst_n_i=0 at an edge: state IDLE, counter 0, iob_ready_o 0, iob_rvalid_o 0, iob_rdata_o 0.
REQ-025 Reset during WAIT or RESP SHALL discard the pending response; no rvalid is emitted afterwards.
REQ-026 Memory array contents SHALL NOT be reset.
REQ-027 iob_ready_o SHALL be 1 in the first cycle after rst_n_i returns to 1 (subject to REQ-029).

Configuration
REQ-028 Macro IOB_MEM_RESPONDER_STALL_EN SHALL enable pseudo-random stall injection.
REQ-029 With it: 8-bit LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset, advancing every cycle; in IDLE and RESP, iob_ready_o SHALL be 0 when lfsr[1:0]==2'b00.
REQ-030 Without it: no LFSR logic; iob_ready_o follows REQ-016/REQ-020 only.

Structure
REQ-031 Package iob_mem_responder_pkg SHALL hold the FSM state typedef (IDLE, WAIT, RESP), LFSR seed 8'hA5, and tap mask 8'hB8.
REQ-032 Sub-module iob_mem_responder_lfsr SHALL implement the LFSR; instantiated only under IOB_MEM_RESPONDER_STALL_EN.

Verification
REQ-033 Reset held 5 cycles, then release -> ready=1 on the first post-reset cycle; rvalid=0; rdata=0.
REQ-034 Write addr 0x0 data 0xDEADBEEF strb 0xF, then read 0x0, LATENCY=2 -> rvalid exactly 2 cycles after accept; rdata 0xDEADBEEF; ready=0 in the intervening cycle.
REQ-035 Write 0x4 data 0x11223344 strb 0xF, then write 0x4 data 0xAABBCCDD strb 0x5, then read 0x4 -> rdata 0x11BB33DD.
REQ-036 Writes to 0x0,0x4,...,0x10 with data 3*addr, then back-to-back reads -> data 0,12,24,36,48 in order; each new read accepted in its predecessor's rvalid cycle.
REQ-037 Read accepted, rst_n_i low one cycle before rvalid is due -> no rvalid ever; subsequent read of same address returns stored data.
REQ-038 With IOB_MEM_RESPONDER_STALL_EN defined: 200 random reads/writes -> all read data match the scoreboard; ready=0 observed at least once in IDLE.
